// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory bus bundle for mem_port_arbiter
//
// Purpose: groups the instruction-fetch port, the data port and the unified
// memory port of mem_port_arbiter into one interface.
// Modports:
//   master - arbiter view: takes requests and mem_rdata, drives grants,
//            read returns and the memory command
//   slave  - environment view (core + memory): the mirror image of master
// Signals:
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata          fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata  data port
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata          memory port

interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port unified memory
//
// Purpose: shares a single-port synchronous memory between the instruction
// fetch port and the data load/store port. Data has fixed priority over
// fetch unless fetch has been starved for STARVE_LIMIT cycles. One read is
// outstanding at a time; read data returns to the owner MEM_LATENCY cycles
// after its grant. A new grant may overlap the read-return cycle.
// Ports:
//   clk            clock
//   rst            synchronous, active-high reset
//   bus            mem_port_arbiter_if.master (fetch, data and memory ports)
//   perf_if_stall  cycles fetch waited for a grant (0 unless ARB_PERF_EN)
//   perf_d_stall   cycles data waited for a grant (0 unless ARB_PERF_EN)
// Build option: define ARB_PERF_EN to build the stall counters.

module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus,
   output logic [31:0]         perf_if_stall,
   output logic [31:0]         perf_d_stall
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam logic       OWN_IF    = 1'b0;
   localparam logic       OWN_D     = 1'b1;
   localparam logic [2:0] LAT_LOAD  = 3'(MEM_LATENCY);
   localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

   state_t      state, state_next;
   logic [2:0]  wait_cnt, wait_cnt_next;
   logic        owner, owner_next;
   logic [3:0]  starve_cnt, starve_next;

   logic              grant_ok;
   logic              return_now;
   logic              if_prio;
   logic              if_gnt_c;
   logic              d_gnt_c;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= 3'd0;
         owner      <= OWN_IF;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_next;
         wait_cnt   <= wait_cnt_next;
         owner      <= owner_next;
         starve_cnt <= starve_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      owner_next    = owner;
      starve_next   = 4'd0;

      if (bus.if_req && !if_gnt_c) begin
         starve_next = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      end

      // A read grant in the return cycle reloads the counter so the memory
      // keeps one read in flight per MEM_LATENCY cycles.
      if (if_gnt_c || (d_gnt_c && !bus.d_we)) begin
         state_next    = S_WAIT;
         wait_cnt_next = LAT_LOAD;
         owner_next    = d_gnt_c ? OWN_D : OWN_IF;
      end else if (state == S_WAIT) begin
         if (wait_cnt == 3'd1) begin
            state_next    = S_IDLE;
            wait_cnt_next = 3'd0;
         end else begin
            wait_cnt_next = wait_cnt - 3'd1;
         end
      end
   end

   // output logic; every strobe is forced low while rst is high
   always_comb begin
      grant_ok   = !rst && ((state == S_IDLE) || (wait_cnt == 3'd1));
      return_now = !rst && (state == S_WAIT) && (wait_cnt == 3'd1);
      if_prio    = (starve_cnt >= STARVE_TH);

      d_gnt_c  = grant_ok && bus.d_req && !(bus.if_req && if_prio);
      if_gnt_c = grant_ok && bus.if_req && !d_gnt_c;

      addr_mux  = '0;
      wdata_mux = '0;
      if (d_gnt_c) begin
         addr_mux  = bus.d_addr;
         wdata_mux = bus.d_wdata;
      end else if (if_gnt_c) begin
         addr_mux  = bus.if_addr;
      end

      bus.if_gnt    = if_gnt_c;
      bus.d_gnt     = d_gnt_c;
      bus.if_rvalid = return_now && (owner == OWN_IF);
      bus.d_rvalid  = return_now && (owner == OWN_D);
      bus.if_rdata  = bus.mem_rdata;
      bus.d_rdata   = bus.mem_rdata;
      bus.mem_en    = if_gnt_c || d_gnt_c;
      bus.mem_we    = d_gnt_c && bus.d_we;
      bus.mem_addr  = addr_mux;
      bus.mem_wdata = wdata_mux;
   end

`ifdef ARB_PERF_EN
   logic [31:0] if_stall_q;
   logic [31:0] d_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         if_stall_q <= 32'd0;
         d_stall_q  <= 32'd0;
      end else begin
         if (bus.if_req && !if_gnt_c) begin
            if_stall_q <= if_stall_q + 32'd1;
         end
         if (bus.d_req && !d_gnt_c) begin
            d_stall_q <= d_stall_q + 32'd1;
         end
      end
   end

   assign perf_if_stall = if_stall_q;
   assign perf_d_stall  = d_stall_q;
`else
   assign perf_if_stall = 32'd0;
   assign perf_d_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 3;
   localparam int SLIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] perf_if_stall;
   logic [31:0] perf_d_stall;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .perf_if_stall(perf_if_stall),
      .perf_d_stall(perf_d_stall)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] init_val(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // memory model: 64 words, read data appears MEM_LATENCY cycles after issue
   logic [31:0] mem  [0:63];
   logic [31:0] pipe [0:LAT-1];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      end else if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      end
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end

   assign bus.mem_rdata = pipe[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: expected read data and return cycle queued at grant
   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        if_q[$];
   exp_t        d_q[$];
   logic [31:0] shadow [0:63];

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if_q.delete();
         d_q.delete();
         for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
      end else begin
         if (bus.if_rvalid) begin
            if (if_q.size() == 0) check_eq("if_rvalid_unexpected", 32'd1, 32'd0);
            else begin
               e = if_q.pop_front();
               check_eq("if_rdata", bus.if_rdata, e.data);
               check_eq("if_rvalid_cycle", 32'(cyc), 32'(e.due));
            end
         end
         if (bus.d_rvalid) begin
            if (d_q.size() == 0) check_eq("d_rvalid_unexpected", 32'd1, 32'd0);
            else begin
               e = d_q.pop_front();
               check_eq("d_rdata", bus.d_rdata, e.data);
               check_eq("d_rvalid_cycle", 32'(cyc), 32'(e.due));
            end
         end
         if (bus.d_gnt && bus.d_we) shadow[bus.d_addr[7:2]] = bus.d_wdata;
         if (bus.if_gnt) if_q.push_back('{shadow[bus.if_addr[7:2]], cyc + LAT});
         if (bus.d_gnt && !bus.d_we) d_q.push_back('{shadow[bus.d_addr[7:2]], cyc + LAT});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] strobes();
      return {26'd0, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we};
   endfunction

   logic [12:0] gi, gd;
   logic [6:0]  en_v, rv_v;
   logic [31:0] p_if0, p_d0;
   logic [31:0] exp_pif, exp_pd;

   initial begin
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      // reset: requests pending, all strobes must stay low
      step();
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b1;
      @(negedge clk);
      check_eq("rst_strobes", strobes(), 32'd0);
      step();
      @(negedge clk);
      check_eq("rst_strobes_2", strobes(), 32'd0);
      step();
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      bus.d_we   = 1'b0;
      @(negedge clk);
      check_eq("rst_perf_if", perf_if_stall, 32'd0);
      check_eq("rst_perf_d", perf_d_stall, 32'd0);

      // single fetch read, granted in its first cycle
      step();
      rst         = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      @(negedge clk);
      check_eq("fetch_gnt", {31'd0, bus.if_gnt}, 32'd1);
      check_eq("fetch_mem_en", {31'd0, bus.mem_en}, 32'd1);
      check_eq("fetch_mem_addr", bus.mem_addr, 32'h10);
      check_eq("fetch_mem_we", {31'd0, bus.mem_we}, 32'd0);
      step();
      bus.if_req = 1'b0;
      @(negedge clk);
      check_eq("fetch_wait_no_en", {31'd0, bus.mem_en}, 32'd0);
      repeat (LAT + 1) step();

      // write vs fetch: data write first, fetch next cycle
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h20;
      bus.d_wdata = 32'hDEAD_BEEF;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h24;
      @(negedge clk);
      check_eq("wr_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
      check_eq("wr_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      check_eq("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
      check_eq("wr_mem_addr", bus.mem_addr, 32'h20);
      check_eq("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      step();
      bus.d_req  = 1'b0;
      bus.d_we   = 1'b0;
      @(negedge clk);
      check_eq("wr_then_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      check_eq("wr_then_mem_wdata", bus.mem_wdata, 32'd0);
      step();
      bus.if_req = 1'b0;
      repeat (LAT + 1) step();

      // read back the written word through the data port
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h20;
      @(negedge clk);
      check_eq("rd_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
      step();
      bus.d_req = 1'b0;
      repeat (LAT + 1) step();

      // starvation guard with continuous data reads
      @(negedge clk);
      p_if0 = perf_if_stall;
      p_d0  = perf_d_stall;
      for (int k = 0; k < 13; k++) begin
         step();
         bus.d_req   = (k <= 9);
         bus.d_we    = 1'b0;
         bus.d_addr  = 32'h40;
         bus.if_req  = 1'b1;
         bus.if_addr = 32'h30;
         @(negedge clk);
         gi[k] = bus.if_gnt;
         gd[k] = bus.d_gnt;
      end
      step();
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      @(negedge clk);
      check_eq("starve_if_gnts", {19'd0, gi}, 32'h1040);
      check_eq("starve_d_gnts", {19'd0, gd}, 32'h0209);
`ifdef ARB_PERF_EN
      exp_pif = 32'd11;
      exp_pd  = 32'd7;
`else
      exp_pif = 32'd0;
      exp_pd  = 32'd0;
`endif
      check_eq("perf_if_delta", perf_if_stall - p_if0, exp_pif);
      check_eq("perf_d_delta", perf_d_stall - p_d0, exp_pd);
      repeat (LAT + 1) step();

      // back-to-back fetch reads
      for (int k = 0; k < 7; k++) begin
         step();
         bus.if_req  = (k <= 3);
         bus.if_addr = (k < 3) ? 32'h50 : 32'h54;
         @(negedge clk);
         en_v[k] = bus.mem_en;
         rv_v[k] = bus.if_rvalid;
      end
      check_eq("b2b_mem_en", {25'd0, en_v}, 32'h09);
      check_eq("b2b_if_rvalid", {25'd0, rv_v}, 32'h48);
      repeat (LAT) step();

      // reset during an outstanding read abandons it
      step();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h58;
      @(negedge clk);
      check_eq("rstw_gnt", {31'd0, bus.if_gnt}, 32'd1);
      step();
      rst        = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b1;
      @(negedge clk);
      check_eq("rstw_strobes_t1", strobes(), 32'd0);
      step();
      @(negedge clk);
      check_eq("rstw_strobes_t2", strobes(), 32'd0);
      step();
      rst         = 1'b0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.if_addr = 32'h5C;
      @(negedge clk);
      check_eq("rstw_no_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
      check_eq("rstw_new_gnt", {31'd0, bus.if_gnt}, 32'd1);
      step();
      bus.if_req = 1'b0;
      repeat (LAT + 2) step();

      check_eq("sb_if_drained", 32'(if_q.size()), 32'd0);
      check_eq("sb_d_drained", 32'(d_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous unified memory between the CPU instruction-fetch port and the data (load/store) port.
- Sits between the core and memory, letting a von Neumann memory replace the separate instruction and data arrays.
- Fixed priority, data over fetch, with a starvation guard for fetch. One outstanding read at a time; read data is returned to the owner after a fixed memory latency.

Parameters:
ADDR_W, 32, address width in bits (byte address, passed through unchanged)
DATA_W, 32, data width in bits
MEM_LATENCY, 1, cycles from issue to valid mem_rdata; legal range 1..7
STARVE_LIMIT, 4, cycles of denied if_req after which fetch gets priority; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  if_rdata valid (one-cycle pulse)
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  d_rdata valid (read only; one-cycle pulse)
d_rdata  out  DATA_W  data read data
mem_en  out  1  memory access issued this cycle (= if_gnt | d_gnt)
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  address of granted requester
mem_wdata  out  DATA_W  d_wdata when data is granted, else 0
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after issue
perf_if_stall  out  32  fetch stall counter (optional feature)
perf_d_stall  out  32  data stall counter (optional feature)

Behaviour:
- Reset: clk rising edge with rst=1 forces state=IDLE, wait counter=0, starve counter=0, owner cleared.
- While rst=1, all gnt, rvalid, mem_en and mem_we outputs are 0. rdata outputs are don't-care.
- States:
  - IDLE: no read outstanding.
  - WAIT: a read is outstanding; owner latched (IF or D); wait counter loaded with MEM_LATENCY at issue and decremented each cycle.
- Grants are allowed in IDLE, or in WAIT when wait counter == 1 (the read-return cycle). No grant in any other cycle.
- Priority when both requests are high:
  - D wins.
  - Exception: IF wins if starve counter >= STARVE_LIMIT.
  - At most one gnt per cycle.
- Starve counter:
  - +1 each cycle if_req=1 and if_gnt=0.
  - Cleared on if_gnt, or when if_req=0.
  - Saturates at 15.
- On a grant:
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the winner.
  - mem_we=1 only for d_gnt with d_we=1.
- Write grant: completes in the issue cycle, with no rvalid. Next state is IDLE unless a read is still returning this cycle.
- Read grant: next state WAIT, owner latched, counter = MEM_LATENCY.
- Read return, in the cycle the counter == 1:
  - owner's rvalid=1; owner's rdata = mem_rdata; the non-owner's rvalid stays 0.
  - If a new read is granted in the same cycle: reload the counter and owner and stay in WAIT. Otherwise go to IDLE.
- Read latency: rvalid exactly MEM_LATENCY cycles after gnt. Back-to-back read throughput is one per MEM_LATENCY cycles.
- A requester may drop req only after its gnt. Dropping it before gnt is illegal and its behaviour is undefined.
- Reset mid-WAIT abandons the read: no rvalid is ever produced for it.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - perf_if_stall +1 each cycle if_req=1 and if_gnt=0.
  - perf_d_stall +1 each cycle d_req=1 and d_gnt=0.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: no counter logic is built; both ports are constant 0.

Test Plan:
- After reset, if_req=1, if_addr=0x10, MEM_LATENCY=1: if_gnt=1 and mem_en=1 in cycle 0; if_rvalid=1 with if_rdata=mem_rdata in cycle 1.
- d_req with d_we=1, addr 0x20, wdata 0xDEADBEEF, and if_req both asserted: d_gnt first, with mem_we=1 and mem_wdata=0xDEADBEEF. if_gnt follows the next cycle; no d_rvalid is ever seen.
- d_req read held high continuously with if_req=1, STARVE_LIMIT=4: after 4 denied fetch cycles, if_gnt=1 on the next grant opportunity, then the starve counter is 0.
- MEM_LATENCY=3, two back-to-back fetch reads: gnt at t0 and t3; if_rvalid at t3 and t6; no mem_en at t1, t2, t4, t5.
- rst asserted at t1 during a MEM_LATENCY=3 read: no rvalid at t3; all outputs are 0 while rst=1; a new request after reset is granted in its first cycle.
- ARB_PERF_EN defined, d_req held for a 3-cycle read stall behind fetch traffic: perf_d_stall=3. With the macro undefined, perf_d_stall reads 0.
